lhn_io_responder: RTL and testbench

Port-mapped I/O responder serving the lhnRISC621 core's IN/OUT instructions. Decodes a 4-bit I/O port address and answers single-cycle read/write strobes with a one-cycle acknowledge. Owns the board peripherals: synchronises and debounces the four switches and the push-button, latches button and switch events, drives the 8 LEDs, and optionally provides a free-running tick timer. Sits between the core's IPDR/OPDR path and the board pins.

---
 rtl/lhn_io_responder_if.sv | 19 +
 rtl/lhn_io_responder.sv | 131 +++++++++++++
 tb/tb_lhn_io_responder.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/lhn_io_responder_if.sv
// Core-side I/O bus for lhn_io_responder: one-cycle rd/wr strobes answered by a one-cycle ack.
interface lhn_io_responder_if;
    logic [3:0]  io_addr;
    logic        io_rd;
    logic        io_wr;
    logic [13:0] io_wdata;
    logic [13:0] io_rdata;
    logic        io_ack;

    modport master (
        output io_addr, io_rd, io_wr, io_wdata,
        input  io_rdata, io_ack
    );

    modport slave (
        input  io_addr, io_rd, io_wr, io_wdata,
        output io_rdata, io_ack
    );
endinterface

// File: rtl/lhn_io_responder.sv
// Port-mapped I/O responder: switch/button debounce, event flags, LED register.
// Define LHN_IO_TIMER_EN to add the 14-bit free-running tick timer on port 3.
module lhn_io_responder #(
    parameter int DB_CYCLES = 4,
    parameter int DB_W      = 16
) (
    input  logic               Clock_pin,
    input  logic               Resetn_pin,
    lhn_io_responder_if.slave  bus,
    input  logic [4:0]         SW_pin,
    output logic [7:0]         Display_pin
);
    typedef enum logic {DB_IDLE, DB_COUNT} db_state_e;

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

    logic [4:0]      sync1_q, sync2_q;
    db_state_e       state_q, state_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic [4:0]      sample_q, sample_d;
    logic [4:0]      stable_q, stable_d;
    logic            btn_evt_q, btn_evt_d;
    logic            sw_evt_q, sw_evt_d;
    logic [7:0]      disp_q, disp_d;
    logic            ack_q;
    logic [13:0]     rdata_q, rdata_d;
    logic            rd_access, wr_access, flag_clr;
`ifdef LHN_IO_TIMER_EN
    logic [13:0]     timer_q, timer_d;
`else
    logic            unused_wdata_hi;
    assign unused_wdata_hi = &{1'b0, bus.io_wdata[13:8]};
`endif

    // A simultaneous rd+wr is a write: no read data and no flag clear.
    assign wr_access = bus.io_wr;
    assign rd_access = bus.io_rd & ~bus.io_wr;
    assign flag_clr  = rd_access && (bus.io_addr == 4'd1);

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sample_d = sample_q;
        stable_d = stable_q;
        case (state_q)
            DB_IDLE: begin
                if (sync2_q != stable_q) begin
                    state_d  = DB_COUNT;
                    cnt_d    = '0;
                    sample_d = sync2_q;
                end
            end
            DB_COUNT: begin
                if (sync2_q != sample_q) begin
                    sample_d = sync2_q;
                    cnt_d    = '0;
                end else if (sync2_q == stable_q) begin
                    state_d = DB_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    stable_d = sample_q;
                    state_d  = DB_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = DB_IDLE;
        endcase
    end

    // A new event at the same edge as a clearing read wins.
    always_comb begin
        btn_evt_d = (~stable_q[4] & stable_d[4]) | (btn_evt_q & ~flag_clr);
        sw_evt_d  = (stable_q[3:0] != stable_d[3:0]) | (sw_evt_q & ~flag_clr);
        disp_d    = (wr_access && bus.io_addr == 4'd2) ? bus.io_wdata[7:0] : disp_q;
`ifdef LHN_IO_TIMER_EN
        timer_d   = (wr_access && bus.io_addr == 4'd3) ? bus.io_wdata : timer_q + 1'b1;
`endif
        rdata_d   = '0;
        if (rd_access) begin
            case (bus.io_addr)
                4'd0:    rdata_d = {9'd0, stable_q};
                4'd1:    rdata_d = {12'd0, sw_evt_q, btn_evt_q};
                4'd2:    rdata_d = {6'd0, disp_q};
`ifdef LHN_IO_TIMER_EN
                4'd3:    rdata_d = timer_q;
`endif
                default: rdata_d = '0;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            state_q   <= DB_IDLE;
            cnt_q     <= '0;
            sample_q  <= '0;
            stable_q  <= '0;
            btn_evt_q <= 1'b0;
            sw_evt_q  <= 1'b0;
            disp_q    <= '0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
`ifdef LHN_IO_TIMER_EN
            timer_q   <= '0;
`endif
        end else begin
            sync1_q   <= SW_pin;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sample_q  <= sample_d;
            stable_q  <= stable_d;
            btn_evt_q <= btn_evt_d;
            sw_evt_q  <= sw_evt_d;
            disp_q    <= disp_d;
            ack_q     <= bus.io_rd | bus.io_wr;
            rdata_q   <= rdata_d;
`ifdef LHN_IO_TIMER_EN
            timer_q   <= timer_d;
`endif
        end
    end

    assign bus.io_ack   = ack_q;
    assign bus.io_rdata = rdata_q;
    assign Display_pin  = disp_q;
endmodule

// File: tb/tb_lhn_io_responder.sv
// Bench for lhn_io_responder: run-length debounce model compared every cycle plus directed literal checks.
module tb_lhn_io_responder;
    localparam int DB_CYCLES = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] sw;
    logic [7:0] disp;
    int         checks = 0;
    int         failures = 0;

    lhn_io_responder_if bus();

    lhn_io_responder #(.DB_CYCLES(DB_CYCLES), .DB_W(16)) dut (
        .Clock_pin   (clk),
        .Resetn_pin  (rst_n),
        .bus         (bus),
        .SW_pin      (sw),
        .Display_pin (disp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: synced is SW as sampled two edges earlier; a value that differs from the accepted
    // one is accepted once it has been seen unchanged for DB_CYCLES+1 consecutive edges.
    logic [4:0]  m_sw_1, m_sw_2, m_last, m_stable, synced, new_stable;
    int          m_run;
    logic        m_btn, m_swe, m_ack, clr;
    logic [7:0]  m_disp;
    logic [13:0] m_timer, m_rdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sw_1 = '0; m_sw_2 = '0; m_last = '0; m_stable = '0; m_run = 0;
            m_btn = 0; m_swe = 0; m_ack = 0; m_disp = '0; m_timer = '0; m_rdata = '0;
        end else begin
            synced = m_sw_2;
            if (synced == m_last) m_run = m_run + 1;
            else m_run = 1;
            m_last = synced;
            new_stable = (synced != m_stable && m_run >= DB_CYCLES + 1) ? synced : m_stable;

            m_ack = bus.io_rd || bus.io_wr;
            m_rdata = '0;
            if (bus.io_rd && !bus.io_wr) begin
                case (bus.io_addr)
                    4'd0: m_rdata = 14'(m_stable);
                    4'd1: m_rdata = 14'({m_swe, m_btn});
                    4'd2: m_rdata = 14'(m_disp);
`ifdef LHN_IO_TIMER_EN
                    4'd3: m_rdata = m_timer;
`endif
                    default: m_rdata = '0;
                endcase
            end
            clr = bus.io_rd && !bus.io_wr && bus.io_addr == 4'd1;
            m_btn = (new_stable[4] && !m_stable[4]) || (m_btn && !clr);
            m_swe = (new_stable[3:0] != m_stable[3:0]) || (m_swe && !clr);
            m_stable = new_stable;
            if (bus.io_wr && bus.io_addr == 4'd2) m_disp = bus.io_wdata[7:0];
            if (bus.io_wr && bus.io_addr == 4'd3) m_timer = bus.io_wdata;
            else m_timer = m_timer + 14'd1;
            m_sw_2 = m_sw_1;
            m_sw_1 = sw;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cyc_ack", 32'(bus.io_ack), 32'(m_ack));
            check("cyc_rdata", 32'(bus.io_rdata), 32'(m_rdata));
            check("cyc_display", 32'(disp), 32'(m_disp));
        end
    end

    // Called at a negedge; returns at the next negedge with the ack-cycle outputs.
    task automatic bus_cycle(input logic rd, input logic wr, input logic [3:0] addr,
                             input logic [13:0] data, output logic [13:0] rdata, output logic ack);
        bus.io_rd = rd; bus.io_wr = wr; bus.io_addr = addr; bus.io_wdata = data;
        @(negedge clk);
        rdata = bus.io_rdata;
        ack = bus.io_ack;
        bus.io_rd = 1'b0; bus.io_wr = 1'b0;
    endtask

    logic [13:0] r;
    logic        a;

    initial begin
        bus.io_rd = 0; bus.io_wr = 0; bus.io_addr = '0; bus.io_wdata = '0;
        sw = 5'h1F;
        repeat (3) @(negedge clk);
        check("rst_display", 32'(disp), 32'h0);
        check("rst_ack", 32'(bus.io_ack), 32'h0);
        check("rst_rdata", 32'(bus.io_rdata), 32'h0);
        rst_n = 1'b1;

        bus_cycle(1, 0, 4'd0, '0, r, a);
        check("port0_pre_debounce", 32'(r), 32'h0);
        check("port0_ack", 32'(a), 32'h1);
        repeat (10) @(negedge clk);
        bus_cycle(1, 0, 4'd0, '0, r, a);
        check("port0_after_debounce", 32'(r), 32'h1F);
        bus_cycle(1, 0, 4'd1, '0, r, a);
        check("flags_after_reset_step", 32'(r), 32'h3);
        bus_cycle(1, 0, 4'd1, '0, r, a);
        check("flags_cleared", 32'(r), 32'h0);

        sw = 5'h00;
        repeat (10) @(negedge clk);
        bus_cycle(1, 0, 4'd1, '0, r, a);
        check("flags_release_no_btn", 32'(r), 32'h2);

        for (int i = 0; i < 10; i++) begin
            sw[0] = ~sw[0];
            @(negedge clk);
        end
        sw[0] = 1'b1;
        bus_cycle(1, 0, 4'd0, '0, r, a);
        check("bounce_not_accepted", 32'(r), 32'h0);
        repeat (10) @(negedge clk);
        bus_cycle(1, 0, 4'd0, '0, r, a);
        check("bounce_settled", 32'(r), 32'h1);
        bus_cycle(1, 0, 4'd1, '0, r, a);
        check("bounce_sw_evt", 32'(r), 32'h2);

        sw = 5'h11;
        repeat (10) @(negedge clk);
        bus_cycle(1, 0, 4'd1, '0, r, a);
        check("btn_press", 32'(r), 32'h1);
        bus_cycle(1, 0, 4'd1, '0, r, a);
        check("btn_second_read", 32'(r), 32'h0);
        sw = 5'h01;
        repeat (10) @(negedge clk);
        bus_cycle(1, 0, 4'd1, '0, r, a);
        check("btn_release", 32'(r), 32'h0);

        bus_cycle(0, 1, 4'd2, 14'h3A5, r, a);
        check("disp_write_pin", 32'(disp), 32'hA5);
        check("disp_write_ack", 32'(a), 32'h1);
        bus_cycle(1, 0, 4'd2, '0, r, a);
        check("disp_read", 32'(r), 32'hA5);
        check("disp_read_ack", 32'(a), 32'h1);
        @(negedge clk);
        check("ack_one_cycle", 32'(bus.io_ack), 32'h0);

        bus_cycle(1, 0, 4'd2, '0, r, a);
        check("b2b_port2", 32'(r), 32'hA5);
        bus_cycle(1, 0, 4'd0, '0, r, a);
        check("b2b_port0", 32'(r), 32'h1);
        bus_cycle(1, 0, 4'd9, '0, r, a);
        check("b2b_port9", 32'(r), 32'h0);
        check("b2b_port9_ack", 32'(a), 32'h1);

        bus_cycle(0, 1, 4'd3, 14'h3FFE, r, a);
        repeat (3) @(negedge clk);
        bus_cycle(1, 0, 4'd3, '0, r, a);
`ifdef LHN_IO_TIMER_EN
        check("timer_wrap", 32'(r), 32'h1);
`else
        check("timer_absent", 32'(r), 32'h0);
`endif
        check("timer_ack", 32'(a), 32'h1);

        bus_cycle(1, 1, 4'd2, 14'h0FF, r, a);
        check("rdwr_rdata", 32'(r), 32'h0);
        check("rdwr_ack", 32'(a), 32'h1);
        check("rdwr_disp", 32'(disp), 32'hFF);
        bus_cycle(0, 1, 4'd0, 14'h3FFF, r, a);
        bus_cycle(1, 0, 4'd0, '0, r, a);
        check("port0_write_ignored", 32'(r), 32'h1);

        sw = 5'h03;
        repeat (6) @(negedge clk);
        bus_cycle(1, 0, 4'd1, '0, r, a);
        check("set_clear_same_edge_old", 32'(r), 32'h0);
        bus_cycle(1, 0, 4'd1, '0, r, a);
        check("set_wins", 32'(r), 32'h2);

        bus.io_rd = 1'b1; bus.io_addr = 4'd0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midaccess_rst_ack", 32'(bus.io_ack), 32'h0);
        check("midaccess_rst_disp", 32'(disp), 32'h0);
        bus.io_rd = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus_cycle(1, 0, 4'd0, '0, r, a);
        check("post_rst_port0", 32'(r), 32'h0);
        repeat (10) @(negedge clk);
        bus_cycle(1, 0, 4'd0, '0, r, a);
        check("post_rst_settled", 32'(r), 32'h3);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
